// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer.
// Purpose: entry kind encodings, default tag geometry and the reserved
// "no dependency" tag. Imported by reorder_buffer and its testbench.
// Ports: none (package).
package reorder_buffer_pkg;

    localparam int ROB_Q_WIDTH = 4;
    localparam int ROB_N       = (1 << ROB_Q_WIDTH) - 1;
    localparam int TAG_NONE    = 0;

    typedef enum logic [1:0] {
        KIND_REG    = 2'd0,
        KIND_STORE  = 2'd1,
        KIND_BRANCH = 2'd2
    } rob_kind_e;

endpackage

// File: rtl/reorder_buffer_ptr_inc.sv
// Wrap-around pointer incrementer for the reorder buffer.
// Purpose: advance a head/tail pointer through 1..2^W-1. Tag 0 is reserved,
// so the all-ones value wraps back to 1 rather than to 0.
// Ports:
//   ptr_in   - current pointer value (never 0)
//   ptr_next - pointer value after one increment
module rob_ptr_inc #(
    parameter int W = 4
) (
    input  logic [W-1:0] ptr_in,
    output logic [W-1:0] ptr_next
);

    always_comb begin
        if (ptr_in == {W{1'b1}}) begin
            ptr_next = W'(1);
        end else begin
            ptr_next = ptr_in + W'(1);
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer for the Tomasulo core.
// Purpose: allocates ROB tags at issue, captures ALU/SLBuffer result
// broadcasts, retires entries in program order and raises a one-cycle
// flush on a mispredicted branch at retirement.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global stall, low = freeze)
//   issue_*            - allocation request; issue_tag/ROB_Full report tail/full
//   qry1_*, qry2_*     - combinational operand lookup from registered state
//   update_control ... - ALU result broadcast (value, taken, target pc)
//   has_slb_result ... - SLBuffer result broadcast (value only)
//   commit_*           - registered one-cycle retirement pulse
//   control_hazard, redirect_pc - registered one-cycle flush and refetch pc
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int Q_WIDTH        = ROB_Q_WIDTH,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      issue_valid,
    input  logic [1:0]                issue_kind,
    input  logic [REG_ADDR_WIDTH-1:0] issue_dest_reg,
    input  logic                      issue_pred_taken,
    output logic [Q_WIDTH-1:0]        issue_tag,
    output logic                      ROB_Full,
    input  logic [Q_WIDTH-1:0]        qry1_tag,
    input  logic [Q_WIDTH-1:0]        qry2_tag,
    output logic                      qry1_ready,
    output logic                      qry2_ready,
    output logic [31:0]               qry1_value,
    output logic [31:0]               qry2_value,
    input  logic                      update_control,
    input  logic [Q_WIDTH-1:0]        target_ROB_pos,
    input  logic [31:0]               V_ex,
    input  logic                      ex_taken,
    input  logic [31:0]               ex_target_pc,
    input  logic                      has_slb_result,
    input  logic [Q_WIDTH-1:0]        slb_target_ROB_pos,
    input  logic [31:0]               V_slb,
    output logic                      commit_valid,
    output logic [Q_WIDTH-1:0]        commit_tag,
    output logic [REG_ADDR_WIDTH-1:0] commit_reg,
    output logic [31:0]               commit_value,
    output logic                      commit_store,
    output logic                      control_hazard,
    output logic [31:0]               redirect_pc
);

    localparam int N     = (1 << Q_WIDTH) - 1;
    localparam int DEPTH = 1 << Q_WIDTH;

    // Entry 0 exists only so tags index the arrays directly; it is never busy.
    logic                      busy_q   [DEPTH];
    logic                      busy_d   [DEPTH];
    logic                      ready_q  [DEPTH];
    logic                      ready_d  [DEPTH];
    rob_kind_e                 kind_q   [DEPTH];
    rob_kind_e                 kind_d   [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] dest_q   [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] dest_d   [DEPTH];
    logic                      pred_q   [DEPTH];
    logic                      pred_d   [DEPTH];
    logic [31:0]               value_q  [DEPTH];
    logic [31:0]               value_d  [DEPTH];
    logic                      taken_q  [DEPTH];
    logic                      taken_d  [DEPTH];
    logic [31:0]               target_q [DEPTH];
    logic [31:0]               target_d [DEPTH];

    logic [Q_WIDTH-1:0] head_q, head_d, head_next;
    logic [Q_WIDTH-1:0] tail_q, tail_d, tail_next;
    logic [Q_WIDTH-1:0] count_q, count_d;

    logic                      commit_valid_q, commit_valid_d;
    logic [Q_WIDTH-1:0]        commit_tag_q, commit_tag_d;
    logic [REG_ADDR_WIDTH-1:0] commit_reg_q, commit_reg_d;
    logic [31:0]               commit_value_q, commit_value_d;
    logic                      commit_store_q, commit_store_d;
    logic                      control_hazard_q, control_hazard_d;
    logic [31:0]               redirect_pc_q, redirect_pc_d;

    logic retire, mispredict, alloc, alu_hit, slb_hit;

    rob_ptr_inc #(.W(Q_WIDTH)) u_head_inc (.ptr_in(head_q), .ptr_next(head_next));
    rob_ptr_inc #(.W(Q_WIDTH)) u_tail_inc (.ptr_in(tail_q), .ptr_next(tail_next));

    assign ROB_Full   = (count_q == Q_WIDTH'(N));
    assign issue_tag  = tail_q;
    assign qry1_ready = busy_q[qry1_tag] && ready_q[qry1_tag];
    assign qry2_ready = busy_q[qry2_tag] && ready_q[qry2_tag];
    assign qry1_value = value_q[qry1_tag];
    assign qry2_value = value_q[qry2_tag];

    assign commit_valid   = commit_valid_q;
    assign commit_tag     = commit_tag_q;
    assign commit_reg     = commit_reg_q;
    assign commit_value   = commit_value_q;
    assign commit_store   = commit_store_q;
    assign control_hazard = control_hazard_q;
    assign redirect_pc    = redirect_pc_q;

    // The flush pulse doubles as "this is the flush cycle": issue and both
    // broadcasts are suppressed while it is high.
    assign retire     = busy_q[head_q] && ready_q[head_q];
    assign mispredict = retire && (kind_q[head_q] == KIND_BRANCH) &&
                        (taken_q[head_q] != pred_q[head_q]);
    assign alloc      = issue_valid && !ROB_Full && !control_hazard_q;
    assign alu_hit    = update_control && !control_hazard_q &&
                        (target_ROB_pos != Q_WIDTH'(TAG_NONE)) && busy_q[target_ROB_pos];
    assign slb_hit    = has_slb_result && !control_hazard_q &&
                        (slb_target_ROB_pos != Q_WIDTH'(TAG_NONE)) && busy_q[slb_target_ROB_pos];

    // Entry and pointer next state. Busy checks use pre-edge state, so a
    // broadcast never hits the entry being allocated in the same cycle.
    // SLBuffer capture is applied after the ALU so it wins on a shared tag.
    always_comb begin
        busy_d   = busy_q;
        ready_d  = ready_q;
        kind_d   = kind_q;
        dest_d   = dest_q;
        pred_d   = pred_q;
        value_d  = value_q;
        taken_d  = taken_q;
        target_d = target_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;

        if (alu_hit) begin
            ready_d[target_ROB_pos]  = 1'b1;
            value_d[target_ROB_pos]  = V_ex;
            taken_d[target_ROB_pos]  = ex_taken;
            target_d[target_ROB_pos] = ex_target_pc;
        end
        if (slb_hit) begin
            ready_d[slb_target_ROB_pos] = 1'b1;
            value_d[slb_target_ROB_pos] = V_slb;
        end

        if (alloc) begin
            busy_d[tail_q]   = 1'b1;
            ready_d[tail_q]  = 1'b0;
            kind_d[tail_q]   = rob_kind_e'(issue_kind);
            dest_d[tail_q]   = issue_dest_reg;
            pred_d[tail_q]   = issue_pred_taken;
            value_d[tail_q]  = 32'd0;
            taken_d[tail_q]  = 1'b0;
            target_d[tail_q] = 32'd0;
            tail_d           = tail_next;
        end

        if (retire) begin
            busy_d[head_q]   = 1'b0;
            ready_d[head_q]  = 1'b0;
            value_d[head_q]  = 32'd0;
            taken_d[head_q]  = 1'b0;
            target_d[head_q] = 32'd0;
            head_d           = head_next;
        end

        if (alloc && !retire) begin
            count_d = count_q + Q_WIDTH'(1);
        end else if (!alloc && retire) begin
            count_d = count_q - Q_WIDTH'(1);
        end

        // A mispredict discards everything, including a same-cycle allocation.
        if (mispredict) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_d[i]  = 1'b0;
                ready_d[i] = 1'b0;
            end
            head_d  = Q_WIDTH'(1);
            tail_d  = Q_WIDTH'(1);
            count_d = '0;
        end
    end

    // Retirement outputs are zero after any stalled or idle edge.
    always_comb begin
        commit_valid_d   = 1'b0;
        commit_tag_d     = '0;
        commit_reg_d     = '0;
        commit_value_d   = 32'd0;
        commit_store_d   = 1'b0;
        control_hazard_d = 1'b0;
        redirect_pc_d    = 32'd0;
        if (rdy_in && retire) begin
            commit_valid_d = 1'b1;
            commit_tag_d   = head_q;
            commit_reg_d   = (kind_q[head_q] == KIND_REG) ? dest_q[head_q] : '0;
            commit_value_d = value_q[head_q];
            commit_store_d = (kind_q[head_q] == KIND_STORE);
            if (mispredict) begin
                control_hazard_d = 1'b1;
                // For branches the value field carries the fall-through pc.
                redirect_pc_d    = taken_q[head_q] ? target_q[head_q] : value_q[head_q];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i]   <= 1'b0;
                ready_q[i]  <= 1'b0;
                kind_q[i]   <= KIND_REG;
                dest_q[i]   <= '0;
                pred_q[i]   <= 1'b0;
                value_q[i]  <= 32'd0;
                taken_q[i]  <= 1'b0;
                target_q[i] <= 32'd0;
            end
            head_q  <= Q_WIDTH'(1);
            tail_q  <= Q_WIDTH'(1);
            count_q <= '0;
        end else if (rdy_in) begin
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            kind_q   <= kind_d;
            dest_q   <= dest_d;
            pred_q   <= pred_d;
            value_q  <= value_d;
            taken_q  <= taken_d;
            target_q <= target_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            commit_valid_q   <= 1'b0;
            commit_tag_q     <= '0;
            commit_reg_q     <= '0;
            commit_value_q   <= 32'd0;
            commit_store_q   <= 1'b0;
            control_hazard_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            commit_valid_q   <= commit_valid_d;
            commit_tag_q     <= commit_tag_d;
            commit_reg_q     <= commit_reg_d;
            commit_value_q   <= commit_value_d;
            commit_store_q   <= commit_store_d;
            control_hazard_q <= control_hazard_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: directed scenarios followed by a randomized
// run, checked against a program-order queue model with a commit scoreboard.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_valid;
    logic [1:0]  issue_kind;
    logic [4:0]  issue_dest_reg;
    logic        issue_pred_taken;
    logic [3:0]  issue_tag;
    logic        ROB_Full;
    logic [3:0]  qry1_tag, qry2_tag;
    logic        qry1_ready, qry2_ready;
    logic [31:0] qry1_value, qry2_value;
    logic        update_control;
    logic [3:0]  target_ROB_pos;
    logic [31:0] V_ex;
    logic        ex_taken;
    logic [31:0] ex_target_pc;
    logic        has_slb_result;
    logic [3:0]  slb_target_ROB_pos;
    logic [31:0] V_slb;
    logic        commit_valid;
    logic [3:0]  commit_tag;
    logic [4:0]  commit_reg;
    logic [31:0] commit_value;
    logic        commit_store;
    logic        control_hazard;
    logic [31:0] redirect_pc;

    reorder_buffer #(.Q_WIDTH(4), .REG_ADDR_WIDTH(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_kind(issue_kind),
        .issue_dest_reg(issue_dest_reg), .issue_pred_taken(issue_pred_taken),
        .issue_tag(issue_tag), .ROB_Full(ROB_Full),
        .qry1_tag(qry1_tag), .qry2_tag(qry2_tag),
        .qry1_ready(qry1_ready), .qry2_ready(qry2_ready),
        .qry1_value(qry1_value), .qry2_value(qry2_value),
        .update_control(update_control), .target_ROB_pos(target_ROB_pos),
        .V_ex(V_ex), .ex_taken(ex_taken), .ex_target_pc(ex_target_pc),
        .has_slb_result(has_slb_result), .slb_target_ROB_pos(slb_target_ROB_pos),
        .V_slb(V_slb),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_reg(commit_reg),
        .commit_value(commit_value), .commit_store(commit_store),
        .control_hazard(control_hazard), .redirect_pc(redirect_pc)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit          iv;
        logic [1:0]  kind;
        logic [4:0]  dest;
        bit          pred;
        bit          uc;
        logic [3:0]  ut;
        logic [31:0] vex;
        bit          tk;
        logic [31:0] tpc;
        bit          sv;
        logic [3:0]  st;
        logic [31:0] vslb;
        bit          rdy;
        logic [3:0]  q1;
        logic [3:0]  q2;
    } stim_t;

    typedef struct {
        int          tag;
        int          kind;
        logic [4:0]  dest;
        bit          pred;
        bit          ready;
        logic [31:0] value;
        bit          taken;
        logic [31:0] target;
    } ent_t;

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic [31:0] value;
        bit          store;
        bit          hazard;
        logic [31:0] redirect;
    } exp_t;

    ent_t rob_m[$];
    exp_t sb[$];
    int   next_tag_m = 1;
    bit   flush_m = 0;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s = '{default: 0};
        s.rdy = 1'b1;
        return s;
    endfunction

    // Model query: an entry is visible only while it is still in flight.
    task automatic lookup(input int tag, output bit rdy, output logic [31:0] val);
        rdy = 0;
        val = 32'd0;
        foreach (rob_m[i]) begin
            if (rob_m[i].tag == tag) begin
                rdy = rob_m[i].ready;
                val = rob_m[i].value;
            end
        end
    endtask

    task automatic applyBroadcast(input int tag, input logic [31:0] val, input bit alu,
                                  input bit tk, input logic [31:0] tpc);
        if (tag == TAG_NONE) return;
        foreach (rob_m[i]) begin
            if (rob_m[i].tag == tag) begin
                rob_m[i].ready = 1;
                rob_m[i].value = val;
                if (alu) begin
                    rob_m[i].taken  = tk;
                    rob_m[i].target = tpc;
                end
            end
        end
    endtask

    // One clock edge of the reference model, using the pre-edge state.
    task automatic modelStep(input stim_t s);
        bit   was_flush;
        bit   full_pre;
        bit   hazard;
        exp_t e;
        ent_t n;
        if (!s.rdy) begin
            flush_m = 0;
            return;
        end
        was_flush = flush_m;
        flush_m   = 0;
        full_pre  = (rob_m.size() == ROB_N);
        hazard    = 0;
        if (rob_m.size() > 0 && rob_m[0].ready) begin
            e.tag      = 4'(rob_m[0].tag);
            e.rd       = (rob_m[0].kind == 0) ? rob_m[0].dest : 5'd0;
            e.value    = rob_m[0].value;
            e.store    = (rob_m[0].kind == 1);
            hazard     = (rob_m[0].kind == 2) && (rob_m[0].taken != rob_m[0].pred);
            e.hazard   = hazard;
            e.redirect = !hazard ? 32'd0 : (rob_m[0].taken ? rob_m[0].target : rob_m[0].value);
            sb.push_back(e);
            void'(rob_m.pop_front());
        end
        if (!was_flush) begin
            if (s.uc) applyBroadcast(int'(s.ut), s.vex, 1, s.tk, s.tpc);
            if (s.sv) applyBroadcast(int'(s.st), s.vslb, 0, 0, 32'd0);
        end
        if (hazard) begin
            rob_m.delete();
            next_tag_m = 1;
            flush_m    = 1;
        end else if (s.iv && !was_flush && !full_pre) begin
            n.tag    = next_tag_m;
            n.kind   = int'(s.kind);
            n.dest   = s.dest;
            n.pred   = s.pred;
            n.ready  = 0;
            n.value  = 32'd0;
            n.taken  = 0;
            n.target = 32'd0;
            rob_m.push_back(n);
            next_tag_m = (next_tag_m % ROB_N) + 1;
        end
    endtask

    task automatic checkOutput(input logic [3:0] q1, input logic [3:0] q2);
        bit          r;
        logic [31:0] v;
        checkEq("issue_tag", 32'(issue_tag), 32'(next_tag_m));
        checkEq("ROB_Full", 32'(ROB_Full), 32'(rob_m.size() == ROB_N));
        lookup(int'(q1), r, v);
        checkEq("qry1_ready", 32'(qry1_ready), 32'(r));
        if (r) checkEq("qry1_value", qry1_value, v);
        lookup(int'(q2), r, v);
        checkEq("qry2_ready", 32'(qry2_ready), 32'(r));
        if (r) checkEq("qry2_value", qry2_value, v);
    endtask

    // Drive one cycle at the falling edge, check, step the model, and
    // return shortly after the rising edge once the monitor has sampled.
    task automatic applyStimulus(input stim_t s);
        @(negedge clk_in);
        rdy_in             = s.rdy;
        issue_valid        = s.iv;
        issue_kind         = s.kind;
        issue_dest_reg     = s.dest;
        issue_pred_taken   = s.pred;
        update_control     = s.uc;
        target_ROB_pos     = s.ut;
        V_ex               = s.vex;
        ex_taken           = s.tk;
        ex_target_pc       = s.tpc;
        has_slb_result     = s.sv;
        slb_target_ROB_pos = s.st;
        V_slb              = s.vslb;
        qry1_tag           = s.q1;
        qry2_tag           = s.q2;
        #1;
        checkOutput(s.q1, s.q2);
        modelStep(s);
        @(posedge clk_in);
        #2;
    endtask

    task automatic driveIdle();
        rdy_in = 1'b1; issue_valid = 1'b0; issue_kind = 2'd0; issue_dest_reg = 5'd0;
        issue_pred_taken = 1'b0; update_control = 1'b0; target_ROB_pos = 4'd0;
        V_ex = 32'd0; ex_taken = 1'b0; ex_target_pc = 32'd0; has_slb_result = 1'b0;
        slb_target_ROB_pos = 4'd0; V_slb = 32'd0; qry1_tag = 4'd0; qry2_tag = 4'd0;
    endtask

    task automatic doReset();
        @(negedge clk_in);
        driveIdle();
        rst_in = 1'b1;
        #1;
        checkEq("rst_issue_tag", 32'(issue_tag), 32'd1);
        checkEq("rst_ROB_Full", 32'(ROB_Full), 32'd0);
        checkEq("rst_commit_valid", 32'(commit_valid), 32'd0);
        checkEq("rst_control_hazard", 32'(control_hazard), 32'd0);
        rob_m.delete();
        sb.delete();
        next_tag_m = 1;
        flush_m    = 0;
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic issueN(input int n, input logic [1:0] kind, input bit pred);
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s = idleStim();
            s.iv = 1; s.kind = kind; s.dest = 5'(i + 1); s.pred = pred;
            applyStimulus(s);
        end
    endtask

    function automatic logic [3:0] pickTag();
        if (rob_m.size() > 0 && $urandom_range(0, 4) != 0)
            return 4'(rob_m[$urandom_range(0, rob_m.size() - 1)].tag);
        return 4'($urandom_range(0, 15));
    endfunction

    // Monitor: the scoreboard holds an entry exactly when a commit is due.
    exp_t mon_e;
    bit   mon_exp;
    always @(posedge clk_in) begin
        #1;
        if (!rst_in) begin
            mon_exp = (sb.size() > 0);
            checkEq("commit_valid", 32'(commit_valid), 32'(mon_exp));
            if (mon_exp) begin
                mon_e = sb.pop_front();
                if (commit_valid) begin
                    checkEq("commit_tag", 32'(commit_tag), 32'(mon_e.tag));
                    checkEq("commit_reg", 32'(commit_reg), 32'(mon_e.rd));
                    checkEq("commit_value", commit_value, mon_e.value);
                    checkEq("commit_store", 32'(commit_store), 32'(mon_e.store));
                    checkEq("control_hazard", 32'(control_hazard), 32'(mon_e.hazard));
                    checkEq("redirect_pc", redirect_pc, mon_e.redirect);
                end
            end else begin
                checkEq("idle_control_hazard", 32'(control_hazard), 32'd0);
            end
        end
    end

    initial begin
        stim_t s;
        int    r;
        rst_in = 1'b1;
        driveIdle();
        #12;
        checkEq("reset_issue_tag", 32'(issue_tag), 32'd1);
        checkEq("reset_ROB_Full", 32'(ROB_Full), 32'd0);
        checkEq("reset_commit_valid", 32'(commit_valid), 32'd0);
        checkEq("reset_qry1_ready", 32'(qry1_ready), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Fill, then retire while full with a dropped issue, then stall.
        issueN(15, 2'd0, 0);
        checkEq("fill_full", 32'(ROB_Full), 32'd1);
        checkEq("fill_issue_tag", 32'(issue_tag), 32'd1);
        s = idleStim(); s.uc = 1; s.ut = 4'd1; s.vex = 32'hAA;
        applyStimulus(s);
        s = idleStim(); s.iv = 1; s.dest = 5'd9;
        applyStimulus(s);
        checkEq("fill_commit_tag", 32'(commit_tag), 32'd1);
        checkEq("fill_commit_value", commit_value, 32'hAA);
        checkEq("fill_not_full", 32'(ROB_Full), 32'd0);
        checkEq("fill_tag_held", 32'(issue_tag), 32'd1);
        for (int i = 0; i < 3; i++) begin
            s = idleStim(); s.rdy = 0; s.iv = 1; s.uc = 1; s.ut = 4'd2; s.vex = 32'h5;
            applyStimulus(s);
            checkEq("stall_commit_valid", 32'(commit_valid), 32'd0);
        end
        checkEq("stall_issue_tag", 32'(issue_tag), 32'd1);
        s = idleStim(); s.q1 = 4'd2;
        applyStimulus(s);

        // Out-of-order results retire in program order.
        doReset();
        issueN(3, 2'd0, 0);
        s = idleStim(); s.uc = 1; s.ut = 4'd3; s.vex = 32'h33; applyStimulus(s);
        s = idleStim(); s.uc = 1; s.ut = 4'd1; s.vex = 32'h11; applyStimulus(s);
        s = idleStim(); s.sv = 1; s.st = 4'd2; s.vslb = 32'h22; applyStimulus(s);
        for (int i = 0; i < 3; i++) applyStimulus(idleStim());

        // Simultaneous broadcasts: same tag (SLB wins) and different tags.
        doReset();
        issueN(6, 2'd1, 0);
        s = idleStim(); s.uc = 1; s.ut = 4'd5; s.vex = 32'h11; s.sv = 1; s.st = 4'd5; s.vslb = 32'h22;
        applyStimulus(s);
        qry1_tag = 4'd5;
        #1;
        checkEq("same_tag_value", qry1_value, 32'h22);
        s = idleStim(); s.uc = 1; s.ut = 4'd2; s.vex = 32'h77; s.sv = 1; s.st = 4'd3; s.vslb = 32'h88;
        applyStimulus(s);
        s = idleStim(); s.q1 = 4'd2; s.q2 = 4'd3;
        applyStimulus(s);
        for (int i = 0; i < 2; i++) begin
            s = idleStim(); s.uc = 1; s.ut = 4'(1 + 3 * i); s.vex = 32'(i);
            applyStimulus(s);
        end
        for (int i = 0; i < 6; i++) applyStimulus(idleStim());

        // Mispredict flush, with issue and broadcast ignored in the flush cycle.
        doReset();
        issueN(1, 2'd2, 0);
        issueN(1, 2'd0, 0);
        s = idleStim(); s.uc = 1; s.ut = 4'd1; s.vex = 32'h44; s.tk = 1; s.tpc = 32'h100;
        applyStimulus(s);
        applyStimulus(idleStim());
        checkEq("flush_control_hazard", 32'(control_hazard), 32'd1);
        checkEq("flush_redirect_pc", redirect_pc, 32'h100);
        s = idleStim(); s.iv = 1; s.uc = 1; s.ut = 4'd1; s.vex = 32'h9;
        applyStimulus(s);
        checkEq("flush_issue_tag", 32'(issue_tag), 32'd1);
        s = idleStim(); s.q1 = 4'd1; s.q2 = 4'd2;
        applyStimulus(s);

        // Randomized traffic with one asynchronous reset mid-run.
        doReset();
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) doReset();
            s = idleStim();
            s.rdy  = ($urandom_range(0, 9) != 0);
            s.iv   = ($urandom_range(0, 9) < 6);
            r      = $urandom_range(0, 9);
            s.kind = (r < 6) ? 2'd0 : ((r < 8) ? 2'd1 : 2'd2);
            s.dest = 5'($urandom);
            s.pred = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                s.uc = 1; s.ut = pickTag(); s.vex = $urandom;
                s.tk = 1'($urandom); s.tpc = $urandom;
            end
            if ($urandom_range(0, 2) == 0) begin
                s.sv = 1; s.st = pickTag(); s.vslb = $urandom;
            end
            s.q1 = 4'($urandom_range(0, 15));
            s.q2 = pickTag();
            applyStimulus(s);
        end
        applyStimulus(idleStim());
        checkEq("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer for the Tomasulo core. It allocates the ROB tags that the reservation stations and load/store buffer wait on, and captures the same ALU and SLBuffer result broadcasts those stations snoop. It retires entries in program order to the register file and SLBuffer. On a branch mispredict at retirement it drives the `control_hazard` flush.

## Interface
- `Q_WIDTH`, 4: tag width. Entries are 1..N with N = 2^Q_WIDTH−1. Tag 0 is reserved and means "no dependency".
- `REG_ADDR_WIDTH`, 5: architectural register index width.
- `clk_in` in 1: clock, rising edge.
- `rst_in` in 1: reset, asynchronous, active-high.
- `rdy_in` in 1: global stall; low freezes all state.
- `issue_valid` in 1: issue unit allocates an entry this cycle.
- `issue_kind` in 2: 0 = reg write, 1 = store, 2 = branch.
- `issue_dest_reg` in REG_ADDR_WIDTH: destination register; ignored unless kind = 0.
- `issue_pred_taken` in 1: predicted direction, branch only.
- `issue_tag` out Q_WIDTH: tag the next allocation will receive (current tail).
- `ROB_Full` out 1: count == N.
- `qry1_tag`, `qry2_tag` in Q_WIDTH: operand lookup for issue.
- `qry1_ready`, `qry2_ready` out 1: queried entry is busy and has its result.
- `qry1_value`, `qry2_value` out 32: stored result of the queried entry.
- `update_control`, `target_ROB_pos` [Q_WIDTH], `V_ex` [32], `ex_taken` [1], `ex_target_pc` [32] in: ALU result broadcast.
- `has_slb_result`, `slb_target_ROB_pos` [Q_WIDTH], `V_slb` [32] in: SLBuffer result broadcast.
- `commit_valid` out 1: one-cycle retire pulse.
- `commit_tag` out Q_WIDTH: tag of the retired entry.
- `commit_reg` out REG_ADDR_WIDTH: destination register; 0 for store/branch.
- `commit_value` out 32: retired result.
- `commit_store` out 1: retired entry is a store; SLBuffer may write memory.
- `control_hazard` out 1: one-cycle flush pulse.
- `redirect_pc` out 32: refetch PC, valid while `control_hazard` = 1.

## Operation
- **Per-entry state:** busy, ready, kind, dest, pred_taken, value, taken, target_pc.
- **Pointers:** `head`, `tail` in 1..N, and `count` in 0..N. Increment wraps N→1; pointers never hold 0.
- **Allocate:** when `issue_valid` is high and `ROB_Full` is low:
  - write the entry at `tail` with busy = 1, ready = 0;
  - `tail` advances; `count` increments.
  - `issue_valid` while full is ignored; the issue unit must not do this.
- **Capture:** on `update_control`, if `target_ROB_pos` ≠ 0 and that entry is busy, set ready = 1, value = `V_ex`, taken = `ex_taken`, target_pc = `ex_target_pc`.
  - `has_slb_result` works the same way with `V_slb`, leaving taken/target_pc unchanged.
  - Both broadcasts on different tags in the same cycle are both applied.
  - Both on the same tag: SLBuffer wins.
  - A broadcast for a non-busy entry or for tag 0 is dropped.
- **Query:** combinational from registered state only. There is no bypass of same-cycle broadcasts; the reservation stations compare those themselves.
- **Retire:** at most one entry per cycle. Entry `head` retires if busy && ready at the start of the cycle.
  - `head` advances; `count` decrements; the entry is cleared.
  - `commit_valid` = 1, and `commit_tag`, `commit_reg`, `commit_value` are driven from the entry.
  - `commit_store` = (kind == 1).
- **Mispredict:** a branch retires with taken ≠ pred_taken.
  - Drive `control_hazard` = 1 and `redirect_pc` = target_pc if taken, else value. For branches, value carries the fall-through PC.
  - At the same edge: all busy = 0, head = tail = 1, count = 0.
  - A correctly predicted branch retires normally with `commit_reg` = 0.
- **Flush cycle:** in the cycle `control_hazard` is high, issue and both broadcasts are ignored.
- **Allocate and retire together:** both take effect in the same cycle; `count` is unchanged. The full check uses the pre-edge count, so a full ROB does not accept an issue in a cycle where it retires.

## Timing
- **Reset:** all outputs 0 except `issue_tag` = 1; head = tail = 1; count = 0; all busy = 0.
- **Assertion during operation:** asynchronous assertion mid-operation discards all entries immediately.
- **Registered outputs:** `commit_*`, `control_hazard`, `redirect_pc`. They are high for exactly the one cycle after the retiring edge, and low after any edge with `rdy_in` = 0 or with no retirement.
- **Latency:**
  - broadcast at edge k → entry ready after k → earliest retirement pulse after edge k+1;
  - allocate at edge k → `issue_tag` updates after k.
- **Combinational outputs:** `ROB_Full`, `issue_tag`, and the query outputs.

## Structure
- **Shared package:** kind encodings (`KIND_REG`, `KIND_STORE`, `KIND_BRANCH`), `ROB_N`, `TAG_NONE` = 0.
- **Sub-module:** `rob_ptr_inc`, the wrap-around incrementer (N→1), instanced for head and tail.

## Test plan
- **Fill and retire:** allocate 15 reg-write entries → `ROB_Full` = 1 and `issue_tag` = 1. Broadcast tag 1, `V_ex` = 0xAA → one cycle later: `commit_valid`, `commit_tag` = 1, `commit_value` = 0xAA, and `ROB_Full` = 0.
- **Out-of-order results:** broadcast tag 3, then tag 1, then tag 2 → retirement order is 1, 2, 3, one per cycle.
- **Mispredict flush:** branch with pred 0 gets `ex_taken` = 1, `ex_target_pc` = 0x100 → `control_hazard` = 1 and `redirect_pc` = 0x100. Next cycle: `issue_tag` = 1, and a query of the old tags returns ready = 0.
- **Simultaneous broadcasts:** ALU and SLB broadcasts on tag 5 in the same cycle (0x11 vs 0x22) → `qry1_value` reads 0x22. Different tags in the same cycle → both ready.
- **Full with simultaneous retire:** full ROB with `issue_valid` and a retirement in the same cycle → issue dropped, `count` = 14. A stall with `rdy_in` = 0 for 3 cycles freezes pointers and holds `commit_valid` = 0.
